// File: rtl/cavlc_zigzag_stats.sv
// CAVLC front end: loads a raster-order 4x4 block, reorders it to zigzag scan order and
// derives TotalCoeff / TrailingOnes / trailing-one signs / TotalZeros behind a valid/ack handshake.
module cavlc_zigzag_stats #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] coeff_in,
  input  logic                  coeff_valid,
  output logic                  in_ready,
  input  logic [3:0]            rd_idx,
  output logic [DATA_WIDTH-1:0] rd_coeff,
  output logic                  stats_valid,
  input  logic                  stats_ack,
  output logic [4:0]            total_coeff,
  output logic [1:0]            trailing_ones,
  output logic [2:0]            t1_signs,
  output logic [3:0]            total_zeros,
  output logic                  BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [3:0]            r_wr_cnt;
  logic [3:0]            r_k;
  logic                  r_seen_nz;
  logic                  r_t1_open;
  logic [4:0]            r_total_coeff;
  logic [1:0]            r_trailing_ones;
  logic [2:0]            r_t1_signs;
  logic [3:0]            r_total_zeros;
  logic [DATA_WIDTH-1:0] r_raster [16];
  logic [DATA_WIDTH-1:0] r_zz     [16];

  logic                  w_accept;
  logic [3:0]            w_map;
  logic [DATA_WIDTH-1:0] w_c;
  logic                  w_is_pm1;

  // zigzag position -> raster index
  always_comb begin
    w_map = 4'd0;
    case (r_k)
      4'd0:  w_map = 4'd0;
      4'd1:  w_map = 4'd1;
      4'd2:  w_map = 4'd4;
      4'd3:  w_map = 4'd8;
      4'd4:  w_map = 4'd5;
      4'd5:  w_map = 4'd2;
      4'd6:  w_map = 4'd3;
      4'd7:  w_map = 4'd6;
      4'd8:  w_map = 4'd9;
      4'd9:  w_map = 4'd12;
      4'd10: w_map = 4'd13;
      4'd11: w_map = 4'd10;
      4'd12: w_map = 4'd7;
      4'd13: w_map = 4'd11;
      4'd14: w_map = 4'd14;
      default: w_map = 4'd15;
    endcase
  end

  assign w_c      = r_raster[w_map];
  // equality compare keeps the most negative value out of the +-1 class
  assign w_is_pm1 = (w_c == DATA_WIDTH'(1)) || (w_c == '1);
  assign w_accept = coeff_valid && in_ready;

  assign in_ready      = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign stats_valid   = (r_state == S_DONE);
  assign BUSY          = (r_state != S_IDLE);
  assign rd_coeff      = r_zz[rd_idx];
  assign total_coeff   = r_total_coeff;
  assign trailing_ones = r_trailing_ones;
  assign t1_signs      = r_t1_signs;
  assign total_zeros   = r_total_zeros;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state         <= S_IDLE;
      r_wr_cnt        <= '0;
      r_k             <= '0;
      r_seen_nz       <= 1'b0;
      r_t1_open       <= 1'b1;
      r_total_coeff   <= '0;
      r_trailing_ones <= '0;
      r_t1_signs      <= '0;
      r_total_zeros   <= '0;
      r_raster        <= '{default: '0};
      r_zz            <= '{default: '0};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_raster[0] <= coeff_in;
            r_wr_cnt    <= 4'd1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_raster[r_wr_cnt] <= coeff_in;
            r_wr_cnt           <= r_wr_cnt + 4'd1;
            if (r_wr_cnt == 4'd15) begin
              r_total_coeff   <= '0;
              r_trailing_ones <= '0;
              r_t1_signs      <= '0;
              r_total_zeros   <= '0;
              r_seen_nz       <= 1'b0;
              r_t1_open       <= 1'b1;
              r_k             <= 4'd15;
              r_state         <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          r_zz[r_k] <= w_c;
          if (w_c != '0) begin
            r_total_coeff <= r_total_coeff + 5'd1;
            r_seen_nz     <= 1'b1;
            if (r_t1_open && w_is_pm1) begin
              r_t1_signs[r_trailing_ones] <= w_c[DATA_WIDTH-1];
              r_trailing_ones             <= r_trailing_ones + 2'd1;
              if (r_trailing_ones == 2'd2) r_t1_open <= 1'b0;
            end else begin
              r_t1_open <= 1'b0;
            end
          end else if (r_seen_nz) begin
            r_total_zeros <= r_total_zeros + 4'd1;
          end
          if (r_k == 4'd0) r_state <= S_DONE;
          else             r_k     <= r_k - 4'd1;
        end
        default: begin
          if (stats_ack) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cavlc_zigzag_stats.sv
// Directed bench for cavlc_zigzag_stats: hand-computed statistics, latency and handshake checks.
module tb_cavlc_zigzag_stats;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] coeff_in = '0;
  logic       coeff_valid = 1'b0;
  logic       in_ready;
  logic [3:0] rd_idx = '0;
  logic [7:0] rd_coeff;
  logic       stats_valid;
  logic       stats_ack = 1'b0;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;
  logic [2:0] t1_signs;
  logic [3:0] total_zeros;
  logic       BUSY;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] blk [16];

  always #5 CLK = ~CLK;

  cavlc_zigzag_stats #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .coeff_in(coeff_in), .coeff_valid(coeff_valid),
    .in_ready(in_ready), .rd_idx(rd_idx), .rd_coeff(rd_coeff),
    .stats_valid(stats_valid), .stats_ack(stats_ack), .total_coeff(total_coeff),
    .trailing_ones(trailing_ones), .t1_signs(t1_signs), .total_zeros(total_zeros),
    .BUSY(BUSY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) blk[i] = v;
  endtask

  task automatic set_mixed();
    fill(8'h00);
    blk[1] = 8'd3; blk[2] = 8'hFF; blk[5] = 8'hFF; blk[6] = 8'd1; blk[8] = 8'd1;
  endtask

  // Streams blk[0..15]; returns 0 if in_ready was ever low when a beat was offered.
  task automatic send_block(input bit gaps, output bit rdy_ok);
    rdy_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int n = $urandom_range(0, 3);
        coeff_valid = 1'b0;
        for (int g = 0; g < n; g++) tick();
      end
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      coeff_valid = 1'b1;
      coeff_in    = blk[i];
      tick();
    end
    coeff_valid = 1'b0;
    coeff_in    = 8'h00;
  endtask

  // Counts cycles from the last accepted beat until stats_valid, bounded.
  task automatic wait_stats(output int cyc, output bit scan_ok);
    cyc = 0;
    scan_ok = 1'b1;
    while (stats_valid !== 1'b1 && cyc < 40) begin
      if (in_ready !== 1'b0 || BUSY !== 1'b1) scan_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic check_stats(input string nm, input logic [4:0] tc, input logic [1:0] t1,
                             input logic [2:0] sg, input logic [3:0] tz);
    vectors++;
    if ({total_coeff, trailing_ones, t1_signs, total_zeros} !== {tc, t1, sg, tz}) begin
      miscompares++;
      $display("FAIL %s: got tc=%0d t1=%0d signs=%b tz=%0d, want tc=%0d t1=%0d signs=%b tz=%0d",
               nm, total_coeff, trailing_ones, t1_signs, total_zeros, tc, t1, sg, tz);
    end
  endtask

  task automatic run_block(input string nm, input bit gaps, input logic [4:0] tc,
                           input logic [1:0] t1, input logic [2:0] sg, input logic [3:0] tz);
    bit rdy_ok, scan_ok;
    int cyc;
    send_block(gaps, rdy_ok);
    wait_stats(cyc, scan_ok);
    vectors++;
    if (!rdy_ok || !scan_ok || cyc != 16) begin
      miscompares++;
      $display("FAIL %s_timing: got latency=%0d load_rdy=%0b scan_ok=%0b, want latency=16 1 1",
               nm, cyc, rdy_ok, scan_ok);
    end
    check_stats(nm, tc, t1, sg, tz);
  endtask

  task automatic do_ack(input string nm);
    stats_ack = 1'b1;
    tick();
    stats_ack = 1'b0;
    vectors++;
    if (stats_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_ack: got stats_valid=%b in_ready=%b, want 0 1", nm, stats_valid, in_ready);
    end
  endtask

  task automatic check_rd(input string nm, input logic [3:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    vectors++;
    if (rd_coeff !== exp) begin
      miscompares++;
      $display("FAIL %s: rd_idx=%0d got %h want %h", nm, idx, rd_coeff, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    rd_idx = 4'd0;
    #1;
    vectors++;
    if ({in_ready, stats_valid, BUSY, total_coeff, trailing_ones, t1_signs, total_zeros, rd_coeff}
        !== {1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 4'd0, 8'h00}) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b sv=%b busy=%b tc=%0d t1=%0d sg=%b tz=%0d rd=%h, want 1 0 0 0 0 000 0 00",
               nm, in_ready, stats_valid, BUSY, total_coeff, trailing_ones, t1_signs, total_zeros, rd_coeff);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(); tick();
    RST = 1'b1;
    check_reset_outputs("reset");
  endtask

  task automatic test_all_zero();
    fill(8'h00);
    run_block("all_zero", 1'b0, 5'd0, 2'd0, 3'b000, 4'd0);
    do_ack("all_zero");
  endtask

  task automatic test_mixed();
    set_mixed();
    run_block("mixed", 1'b0, 5'd5, 2'd3, 3'b110, 4'd3);
    check_rd("mixed_rd1", 4'd1, 8'd3);
    check_rd("mixed_rd7", 4'd7, 8'd1);
    check_rd("mixed_rd4", 4'd4, 8'hFF);
    check_rd("mixed_rd2", 4'd2, 8'h00);
    do_ack("mixed");
  endtask

  task automatic test_single_last();
    fill(8'h00);
    blk[15] = 8'hFE;
    run_block("neg2_last", 1'b0, 5'd1, 2'd0, 3'b000, 4'd15);
    check_rd("neg2_rd15", 4'd15, 8'hFE);
    do_ack("neg2_last");
    blk[15] = 8'h80;
    run_block("min_last", 1'b0, 5'd1, 2'd0, 3'b000, 4'd15);
    check_rd("min_rd15", 4'd15, 8'h80);
    do_ack("min_last");
  endtask

  task automatic test_all_ones();
    fill(8'h01);
    run_block("all_p1", 1'b0, 5'd16, 2'd3, 3'b000, 4'd0);
    do_ack("all_p1");
    fill(8'hFF);
    run_block("all_m1", 1'b0, 5'd16, 2'd3, 3'b111, 4'd0);
    check_rd("all_m1_rd9", 4'd9, 8'hFF);
    do_ack("all_m1");
  endtask

  task automatic test_gaps();
    set_mixed();
    run_block("gaps", 1'b1, 5'd5, 2'd3, 3'b110, 4'd3);
    do_ack("gaps");
  endtask

  task automatic test_ack_hold();
    bit rdy_ok, hold_ok;
    int cyc;
    set_mixed();
    send_block(1'b0, rdy_ok);
    cyc = 0;
    while (stats_valid !== 1'b1 && cyc < 40) begin
      coeff_valid = cyc[0];
      coeff_in    = 8'h07;
      tick();
      cyc++;
    end
    vectors++;
    if (cyc != 16) begin
      miscompares++;
      $display("FAIL hold_latency: got %0d want 16", cyc);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      coeff_valid = (i % 3 == 0);
      tick();
      if (stats_valid !== 1'b1 || in_ready !== 1'b0 || BUSY !== 1'b1 ||
          {total_coeff, trailing_ones, t1_signs, total_zeros} !== {5'd5, 2'd3, 3'b110, 4'd3})
        hold_ok = 1'b0;
    end
    coeff_valid = 1'b0;
    coeff_in    = 8'h00;
    vectors++;
    if (!hold_ok) begin
      miscompares++;
      $display("FAIL ack_hold: got outputs changed during hold, want stable stats_valid=1 in_ready=0");
    end
    check_stats("hold_stats", 5'd5, 2'd3, 3'b110, 4'd3);
    check_rd("hold_rd1", 4'd1, 8'd3);
    do_ack("hold");
    fill(8'h00);
    blk[0] = 8'h02;
    run_block("after_hold", 1'b0, 5'd1, 2'd0, 3'b000, 4'd0);
    do_ack("after_hold");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      coeff_valid = 1'b1;
      coeff_in    = 8'd5;
      tick();
    end
    RST = 1'b0;
    tick();
    RST = 1'b1;
    coeff_valid = 1'b0;
    check_reset_outputs("reset_mid");
    fill(8'h00);
    blk[15] = 8'hFE;
    run_block("post_reset", 1'b0, 5'd1, 2'd0, 3'b000, 4'd15);
    do_ack("post_reset");
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_mixed();
    test_single_last();
    test_all_ones();
    test_reset_mid();
    test_gaps();
    test_ack_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
